task_3_datapath: RTL and testbench
==================================

TASK_3_DATAPATH -- requirements
Module: task_3_datapath

Interface
REQ-001 Parameter: DWIDTH, default 8, data/accumulator/instruction width.
REQ-002 Parameter: AWIDTH, default 5, memory address and PC width (32 words).
REQ-003 Port: clk, input, 1, single clock; all state updates on rising edge.
REQ-004 Port: rst, input, 1, asynchronous active-low reset.
REQ-005 Port: sel, input, 1, address select; 1 selects PC, 0 selects IR operand field.
REQ-006 Port: mem_rd, input, 1, memory read enable.
REQ-007 Port: mem_wr, input, 1, memory write enable (store AC).
REQ-008 Port: load_ir, input, 1, load instruction register from memory data.
REQ-009 Port: load_ac, input, 1, load accumulator from ALU result.
REQ-010 Port: load_pc, input, 1, load PC from IR operand field.
REQ-011 Port: inc_pc, input, 1, increment PC.
REQ-012 Port: halt, input, 1, freeze all architectural state.
REQ-013 Port: prog_we, input, 1, program-load write strobe.
REQ-014 Port: prog_addr, input, AWIDTH, program-load address.
REQ-015 Port: prog_data, input, DWIDTH, program-load data.
REQ-016 Port: opcode, output, 3, IR[7:5], returned to controller.
REQ-017 Port: Zero, output, 1, high when AC == 0.
REQ-018 Port: pc_out, output, AWIDTH, current PC.
REQ-019 Port: ac_out, output, DWIDTH, current AC.

Function
REQ-020 Memory address SHALL be PC when sel=1, else IR[4:0].
REQ-021 Memory read SHALL be combinational: mem_data = mem[addr] when mem_rd=1, else 0.
REQ-022 When mem_wr=1 and halt=0, mem[IR[4:0]] SHALL be written with AC at the clock edge.
REQ-023 When prog_we=1, mem[prog_addr] SHALL be written with prog_data regardless of halt; prog_we has priority over mem_wr when both are high in the same cycle.
REQ-024 When load_ir=1 and halt=0, IR SHALL capture mem_data.
REQ-025 ALU by opcode: 010 ADD AC+data mod 2^DWIDTH (carry dropped); 011 AND; 100 XOR; 101 LDA (pass data); all others pass AC unchanged.
REQ-026 When load_ac=1 and halt=0, AC SHALL capture the ALU result.
REQ-027 PC update: load_pc loads IR[4:0]; otherwise inc_pc adds 1 with wrap 31 -> 0; load_pc has priority when both are high.
REQ-028 When halt=1, PC, IR, AC and memory (except prog_we) SHALL hold; outputs remain valid.
REQ-029 Zero SHALL be decoded combinationally from the registered AC only.
REQ-030 opcode SHALL be decoded combinationally from the registered IR only.
REQ-031 Latency: a register load is visible on outputs one cycle after the strobe edge.

Reset
REQ-032 rst low SHALL asynchronously force PC=0, IR=0, AC=0, giving opcode=000, Zero=1, pc_out=0, ac_out=0.
REQ-033 Memory contents SHALL NOT be reset.
REQ-034 Reset asserted mid-instruction SHALL discard any in-flight strobe; the first edge after release SHALL act normally.

Structure
REQ-035 Shared package SHALL hold opcode constants (HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111) and DWIDTH/AWIDTH defaults; the controller uses the same package.
REQ-036 Memory array and write-port arbitration SHALL be the sub-module task_3_memory; PC, IR, AC and ALU remain in task_3_datapath.

Verification
REQ-037 Reset: rst=0 at t=10 -> PC=0, AC=0, opcode=000, Zero=1 immediately, without waiting for a clock edge.
REQ-038 Fetch/LDA: preload mem[0]=8'hA3, mem[3]=8'h07; sel=1, mem_rd=1, load_ir=1 -> opcode=101; then sel=0, mem_rd=1, load_ac=1 -> AC=07, Zero=0.
REQ-039 ADD wrap: AC=8'hFF, operand 8'h01, ADD with load_ac -> AC=00, Zero=1.
REQ-040 STO: AC=8'h5A, IR=8'hC9, mem_wr=1 -> mem[9]=5A; simultaneous prog_we to addr 9 with data 11 -> mem[9]=11.
REQ-041 PC: PC=31, inc_pc -> 0; IR=8'hE4, load_pc=1 and inc_pc=1 together -> PC=4.
REQ-042 Halt: halt=1 with load_ac, inc_pc and mem_wr all high for 3 cycles -> PC, AC and memory unchanged.

Source files
------------

// File: rtl/task_3_pkg.sv
// Shared definitions for the task_3 datapath and its controller.
// Holds the opcode encoding and the default data and address widths.
package task_3_pkg;

  localparam int DWIDTH_DEF = 8;
  localparam int AWIDTH_DEF = 5;
  localparam int OPWIDTH    = 3;

  typedef enum logic [OPWIDTH-1:0] {
    OP_HLT = 3'b000,
    OP_SKZ = 3'b001,
    OP_ADD = 3'b010,
    OP_AND = 3'b011,
    OP_XOR = 3'b100,
    OP_LDA = 3'b101,
    OP_STO = 3'b110,
    OP_JMP = 3'b111
  } opcode_e;

endpackage

// File: rtl/task_3_memory.sv
// Single-array program/data memory with a combinational read port.
// A program-load write takes priority over a CPU store in the same cycle.
module task_3_memory #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 5
) (
  input  logic              clk,
  input  logic [AWIDTH-1:0] rd_addr,
  input  logic              rd_en,
  output logic [DWIDTH-1:0] rd_data,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              prog_we,
  input  logic [AWIDTH-1:0] prog_addr,
  input  logic [DWIDTH-1:0] prog_data
);

  logic [DWIDTH-1:0] mem [2**AWIDTH];

  assign rd_data = rd_en ? mem[rd_addr] : '0;

  // Contents deliberately survive reset so a loaded program is kept.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/task_3_datapath.sv
// Accumulator-machine datapath: PC, IR, AC and ALU around task_3_memory.
// All sequencing strobes come from an external controller.
module task_3_datapath
  import task_3_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sel,
  input  logic               mem_rd,
  input  logic               mem_wr,
  input  logic               load_ir,
  input  logic               load_ac,
  input  logic               load_pc,
  input  logic               inc_pc,
  input  logic               halt,
  input  logic               prog_we,
  input  logic [AWIDTH-1:0]  prog_addr,
  input  logic [DWIDTH-1:0]  prog_data,
  output logic [OPWIDTH-1:0] opcode,
  output logic               Zero,
  output logic [AWIDTH-1:0]  pc_out,
  output logic [DWIDTH-1:0]  ac_out
);

  logic [AWIDTH-1:0] pc;
  logic [DWIDTH-1:0] ir;
  logic [DWIDTH-1:0] ac;
  logic [DWIDTH-1:0] alu_res;
  logic [DWIDTH-1:0] mem_data;
  logic [AWIDTH-1:0] operand;
  logic [AWIDTH-1:0] addr;
  logic              store_en;
  opcode_e           op;

  assign operand = ir[AWIDTH-1:0];
  assign op      = opcode_e'(ir[DWIDTH-1 -: OPWIDTH]);
  assign addr    = sel ? pc : operand;

  // A store held across reset must not land once reset releases mid-cycle.
  assign store_en = mem_wr & ~halt & rst;

  task_3_memory #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_mem (
    .clk       (clk),
    .rd_addr   (addr),
    .rd_en     (mem_rd),
    .rd_data   (mem_data),
    .wr_en     (store_en),
    .wr_addr   (operand),
    .wr_data   (ac),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data)
  );

  always_comb begin
    alu_res = ac;
    case (op)
      OP_ADD:  alu_res = ac + mem_data;
      OP_AND:  alu_res = ac & mem_data;
      OP_XOR:  alu_res = ac ^ mem_data;
      OP_LDA:  alu_res = mem_data;
      default: alu_res = ac;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= '0;
      ir <= '0;
      ac <= '0;
    end else if (!halt) begin
      if (load_ir) ir <= mem_data;
      if (load_ac) ac <= alu_res;
      if (load_pc) begin
        pc <= operand;
      end else if (inc_pc) begin
        pc <= pc + AWIDTH'(1);
      end
    end
  end

  assign opcode = ir[DWIDTH-1 -: OPWIDTH];
  assign Zero   = (ac == '0);
  assign pc_out = pc;
  assign ac_out = ac;

endmodule

// File: tb/tb_task_3_datapath.sv
// Directed bench for task_3_datapath: hand-computed expectations checked
// with immediate assertions after each step.
module tb_task_3_datapath;

  logic       clk;
  logic       rst;
  logic       sel, mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc, halt;
  logic       prog_we;
  logic [4:0] prog_addr;
  logic [7:0] prog_data;
  logic [2:0] opcode;
  logic       Zero;
  logic [4:0] pc_out;
  logic [7:0] ac_out;

  int n_cmp = 0;
  int n_err = 0;

  task_3_datapath #(.DWIDTH(8), .AWIDTH(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .sel       (sel),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .load_ir   (load_ir),
    .load_ac   (load_ac),
    .load_pc   (load_pc),
    .inc_pc    (inc_pc),
    .halt      (halt),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .opcode    (opcode),
    .Zero      (Zero),
    .pc_out    (pc_out),
    .ac_out    (ac_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    sel = 0; mem_rd = 0; mem_wr = 0; load_ir = 0; load_ac = 0;
    load_pc = 0; inc_pc = 0; halt = 0; prog_we = 0;
  endtask

  task automatic prog(input logic [4:0] a, input logic [7:0] d);
    prog_we = 1; prog_addr = a; prog_data = d;
    @(negedge clk);
    prog_we = 0;
  endtask

  task automatic fetch();
    sel = 1; mem_rd = 1; load_ir = 1; inc_pc = 1;
    @(negedge clk);
    clr();
  endtask

  task automatic exec_ac();
    sel = 0; mem_rd = 1; load_ac = 1;
    @(negedge clk);
    clr();
  endtask

  initial begin
    rst = 1; prog_addr = '0; prog_data = '0;
    clr();

    // asynchronous reset, checked between clock edges
    #10 rst = 0;
    #1;
    check("rst_pc", 8'(pc_out), 8'h00);
    check("rst_ac", ac_out, 8'h00);
    check("rst_opcode", 8'(opcode), 8'h00);
    check("rst_zero", 8'(Zero), 8'h01);

    @(negedge clk);
    prog(5'd0, 8'hA3);
    prog(5'd3, 8'h07);
    prog(5'd1, 8'hA4);
    prog(5'd4, 8'hFF);
    prog(5'd2, 8'h45);
    prog(5'd5, 8'h01);
    check("rst_hold_pc", 8'(pc_out), 8'h00);
    rst = 1;

    // fetch / LDA
    fetch();
    check("fetch_opcode", 8'(opcode), 8'h05);
    check("fetch_pc", 8'(pc_out), 8'h01);
    exec_ac();
    check("lda_ac", ac_out, 8'h07);
    check("lda_zero", 8'(Zero), 8'h00);

    // ADD wrap
    fetch();
    exec_ac();
    check("lda_ff", ac_out, 8'hFF);
    fetch();
    check("add_opcode", 8'(opcode), 8'h02);
    exec_ac();
    check("add_wrap_ac", ac_out, 8'h00);
    check("add_wrap_zero", 8'(Zero), 8'h01);

    // STO
    prog(5'd16, 8'h5A);
    prog(5'd3, 8'hB0);
    prog(5'd9, 8'h00);
    fetch();
    exec_ac();
    check("sto_ac", ac_out, 8'h5A);
    prog(5'd4, 8'hC9);
    fetch();
    check("sto_opcode", 8'(opcode), 8'h06);
    mem_wr = 1;
    @(negedge clk);
    clr();
    prog(5'd5, 8'hA9);
    fetch();
    exec_ac();
    check("sto_mem9", ac_out, 8'h5A);

    // prog_we beats mem_wr on the same address
    prog(5'd6, 8'hC9);
    fetch();
    mem_wr = 1; prog_we = 1; prog_addr = 5'd9; prog_data = 8'h11;
    @(negedge clk);
    clr();
    prog(5'd7, 8'hA9);
    fetch();
    exec_ac();
    check("prog_priority", ac_out, 8'h11);

    // PC wrap and load_pc priority
    prog(5'd8, 8'hFF);
    fetch();
    check("jmp_fetch_pc", 8'(pc_out), 8'h09);
    load_pc = 1;
    @(negedge clk);
    clr();
    check("load_pc_31", 8'(pc_out), 8'h1F);
    inc_pc = 1;
    @(negedge clk);
    clr();
    check("pc_wrap", 8'(pc_out), 8'h00);
    prog(5'd0, 8'hE4);
    fetch();
    check("jmp_opcode", 8'(opcode), 8'h07);
    load_pc = 1; inc_pc = 1;
    @(negedge clk);
    clr();
    check("load_pc_prio", 8'(pc_out), 8'h04);

    // halt freezes PC, IR, AC and memory
    prog(5'd4, 8'h4A);
    prog(5'd10, 8'h22);
    fetch();
    check("halt_pre_pc", 8'(pc_out), 8'h05);
    halt = 1; load_ac = 1; inc_pc = 1; mem_wr = 1; load_ir = 1; sel = 0; mem_rd = 1;
    repeat (3) @(negedge clk);
    clr();
    check("halt_pc", 8'(pc_out), 8'h05);
    check("halt_ac", ac_out, 8'h11);
    check("halt_opcode", 8'(opcode), 8'h02);
    exec_ac();
    check("halt_mem_add", ac_out, 8'h33);

    // AND, XOR, and a non-ALU opcode passing AC through
    prog(5'd5, 8'h6B);
    prog(5'd6, 8'h8B);
    prog(5'd7, 8'h2B);
    prog(5'd11, 8'h0F);
    fetch();
    exec_ac();
    check("and_ac", ac_out, 8'h03);
    fetch();
    exec_ac();
    check("xor_ac", ac_out, 8'h0C);
    fetch();
    exec_ac();
    check("skz_pass_ac", ac_out, 8'h0C);
    check("skz_opcode", 8'(opcode), 8'h01);

    // reset mid-cycle with strobes in flight
    inc_pc = 1; load_ac = 1;
    #2 rst = 0;
    #1;
    check("mid_rst_pc", 8'(pc_out), 8'h00);
    check("mid_rst_ac", ac_out, 8'h00);
    check("mid_rst_opcode", 8'(opcode), 8'h00);
    check("mid_rst_zero", 8'(Zero), 8'h01);
    @(negedge clk);
    check("rst_discard_pc", 8'(pc_out), 8'h00);
    rst = 1;
    @(negedge clk);
    clr();
    check("post_rst_pc", 8'(pc_out), 8'h01);

    // memory survives reset
    fetch();
    check("mem_kept_opcode", 8'(opcode), 8'h05);
    exec_ac();
    check("mem_kept_ac", ac_out, 8'h4A);

    // read with mem_rd low returns zero
    sel = 0; mem_rd = 0; load_ac = 1;
    @(negedge clk);
    clr();
    check("rd_off_ac", ac_out, 8'h00);
    check("rd_off_zero", 8'(Zero), 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
